// File: rtl/rr_arbiter4_dec_if.sv
// rr_arbiter4_dec_if: request/grant bundle between requesters and the 4-way round-robin arbiter.
interface rr_arbiter4_dec_if;
  logic       En;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  modport master (output En, req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input En, req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter4_dec.sv
// rr_arbiter4_dec: 4-requester round-robin arbiter, one-hot grant via a 2-to-4 enabled decoder.
// Define ARB4_TIMEOUT_EN to add a hold watchdog that revokes a grant after MAX_HOLD busy cycles.
module decoder2to4withEnable (
  input  logic i1,
  input  logic i0,
  input  logic En,
  output logic o3,
  output logic o2,
  output logic o1,
  output logic o0
);
  assign o0 = En & ~i1 & ~i0;
  assign o1 = En & ~i1 &  i0;
  assign o2 = En &  i1 & ~i0;
  assign o3 = En &  i1 &  i0;
endmodule

module rr_arbiter4_dec #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input logic Clk,
  input logic Rst,
  rr_arbiter4_dec_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  if (MAX_HOLD >= 2 ** CNT_W) begin : g_bad_cfg
    $error("CNT_W too narrow for MAX_HOLD");
  end
  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, pick;
  logic       gnt_valid_q, gnt_valid_d;
  logic [3:0] rot;
  logic       own, expire, go, done;
  // rot[i] is the request i places after the priority pointer
  always_comb begin
    rot = '0;
    for (int i = 0; i < 4; i++) rot[i] = bus.req[ptr_q + 2'(i)];
    pick = ptr_q + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    own = bus.req[gnt_idx_q];
    go = state_q == IDLE && bus.En && |bus.req;
    done = state_q == BUSY && (!own || !bus.En || expire);
    state_d = go ? BUSY : done ? IDLE : state_q;
    gnt_idx_d = go ? pick : gnt_idx_q;
    gnt_valid_d = go ? 1'b1 : done ? 1'b0 : gnt_valid_q;
    ptr_d = done ? gnt_idx_q + 2'd1 : ptr_q;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_idx_q <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end
`ifdef ARB4_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
  // a release on the expiry edge counts as a normal release, hence the own term
  always_comb begin
    expire = hold_q == CNT_W'(MAX_HOLD);
    hold_d = go ? '0 : state_q == BUSY ? hold_q + CNT_W'(1) : hold_q;
    timeout_d = state_q == BUSY && own && expire;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  decoder2to4withEnable u_dec (
    .i1(gnt_idx_q[1]),
    .i0(gnt_idx_q[0]),
    .En(gnt_valid_q),
    .o3(bus.gnt[3]),
    .o2(bus.gnt[2]),
    .o1(bus.gnt[1]),
    .o0(bus.gnt[0])
  );
endmodule

// File: tb/tb_rr_arbiter4_dec.sv
// tb_rr_arbiter4_dec: scoreboard bench for the round-robin arbiter (covers ARB4_TIMEOUT_EN builds too).
module tb_rr_arbiter4_dec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  logic [4:0] sb[$];
  rr_arbiter4_dec_if bus ();
  rr_arbiter4_dec #(.MAX_HOLD(3), .CNT_W(4)) dut (.Clk(clk), .Rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // drive one cycle; expected {timeout, gnt} after the edge goes through the scoreboard
  task automatic cyc(input logic en, input logic [3:0] req, input logic [3:0] eg, input logic eto = 1'b0);
    logic [4:0] e;
    bus.En = en;
    bus.req = req;
    sb.push_back({eto, eg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", 32'(bus.gnt), 32'(e[3:0]));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(|e[3:0]));
    check("timeout", 32'(bus.timeout), 32'(e[4]));
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.gnt_valid), 32'd0);
    check("rst_idx", 32'(bus.gnt_idx), 32'd0);
    #1 rst = 1'b0;
  endtask
  initial begin
    bus.En = 1'b1;
    bus.req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_gnt", 32'(bus.gnt), 32'd0);
      check("reset_valid", 32'(bus.gnt_valid), 32'd0);
      check("reset_idx", 32'(bus.gnt_idx), 32'd0);
      check("reset_to", 32'(bus.timeout), 32'd0);
    end
    rst = 1'b0;
    cyc(1, 4'b1010, 4'b0010);
    check("idx1", 32'(bus.gnt_idx), 32'd1);
    cyc(1, 4'b1000, 4'b0000);
    check("idx_kept", 32'(bus.gnt_idx), 32'd1);
    cyc(1, 4'b1000, 4'b1000);
    cyc(1, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      cyc(1, 4'hF, oh);
      cyc(1, 4'hF, oh);
      cyc(1, 4'hF & ~oh, 4'b0000);
    end
    cyc(1, 4'hF, 4'b0001);
    cyc(1, 4'b0000, 4'b0000);
    cyc(1, 4'b0100, 4'b0100);
    check("idx2", 32'(bus.gnt_idx), 32'd2);
    cyc(0, 4'b0100, 4'b0000);
    cyc(0, 4'b0100, 4'b0000);
    cyc(0, 4'b0110, 4'b0000);
    cyc(1, 4'b0100, 4'b0100);
    cyc(1, 4'b0000, 4'b0000);
    cyc(1, 4'b1000, 4'b1000);
    cyc(1, 4'b0001, 4'b0000);
    cyc(1, 4'b0001, 4'b0001);
    cyc(1, 4'b0000, 4'b0000);
    cyc(1, 4'b0011, 4'b0010);
    cyc(1, 4'b0001, 4'b0000);
    cyc(1, 4'b0011, 4'b0001);
    cyc(1, 4'b0000, 4'b0000);
    cyc(1, 4'b0100, 4'b0100);
    pulse_rst();
    cyc(1, 4'b0001, 4'b0001);
    cyc(1, 4'b0000, 4'b0000);
    pulse_rst();
    cyc(1, 4'b0011, 4'b0001);
`ifdef ARB4_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc(1, 4'b0011, 4'b0001);
    cyc(1, 4'b0011, 4'b0000, 1'b1);
    cyc(1, 4'b0011, 4'b0010);
`else
    for (int i = 0; i < 50; i++) cyc(1, 4'b0011, 4'b0001);
`endif
    cyc(1, 4'b0000, 4'b0000);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
